// File: rtl/pid_controller_mc.sv
`default_nettype none
// ============================================================================
//  Module      : pid_controller_mc
//  Description : Time-multiplexed PID controller. One start pulse sweeps all
//                CHANNELS through a shared LOAD/MUL/SUM/STORE datapath. Each
//                channel produces a saturated duty word with a deadband and a
//                clamped integral.
//  Optional    : PID_DERIVATIVE_EN - when defined, builds the Kd term, the
//                per-channel err_prev registers and the KD_DIV sweep counter.
//                When undefined, the Kd term is 0 and the Kd port is ignored.
//  Ports       : CLK            - clock, rising edge
//                reset          - asynchronous, active-high
//                start          - one-cycle sweep request (ignored while busy)
//                busy           - high while a sweep runs
//                done           - one-cycle pulse after the last channel store
//                setpoint/state - packed signed per-channel inputs, ch0 in LSBs
//                Kp/Ki/Kd       - packed signed per-channel gains
//                PWMLimit/IntegralLimit/deadband - packed signed per-channel
//                duty           - packed signed registered per-channel result
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_controller_mc #(
  parameter int WIDTH     = 24,
  parameter int CHANNELS  = 4,
  parameter int FRAC_BITS = 0,
  parameter int KD_DIV    = 128
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic [CHANNELS*WIDTH-1:0]    setpoint,
  input  logic [CHANNELS*WIDTH-1:0]    state,
  input  logic [CHANNELS*WIDTH-1:0]    Kp,
  input  logic [CHANNELS*WIDTH-1:0]    Ki,
  input  logic [CHANNELS*WIDTH-1:0]    Kd,
  input  logic [CHANNELS*WIDTH-1:0]    PWMLimit,
  input  logic [CHANNELS*WIDTH-1:0]    IntegralLimit,
  input  logic [CHANNELS*WIDTH-1:0]    deadband,
  output logic [CHANNELS*WIDTH-1:0]    duty
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int SW   = 2 * WIDTH + 2;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    SUM   = 3'd3,
    STORE = 3'd4
  } fsm_t;

  fsm_t                       r_fsm;
  logic                       r_busy;
  logic                       r_done;
  logic [CH_W-1:0]            r_ch;
  logic signed [WIDTH-1:0]    r_err;
  logic signed [PW-1:0]       r_pterm;
  logic signed [PW-1:0]       r_iterm;
  logic signed [PW-1:0]       r_dterm;
  logic signed [SW-1:0]       r_sum;
  logic [CHANNELS*WIDTH-1:0]  r_duty;
  logic signed [WIDTH-1:0]    r_integral [CHANNELS];

  // Current channel's operands
  logic signed [WIDTH-1:0]    w_sp, w_st, w_kp, w_ki;
  logic signed [WIDTH-1:0]    w_pwm_raw, w_ilim_raw, w_db;
  logic signed [WIDTH-1:0]    w_pwm, w_ilim, w_integ;

  assign w_sp       = $signed(setpoint[r_ch*WIDTH +: WIDTH]);
  assign w_st       = $signed(state[r_ch*WIDTH +: WIDTH]);
  assign w_kp       = $signed(Kp[r_ch*WIDTH +: WIDTH]);
  assign w_ki       = $signed(Ki[r_ch*WIDTH +: WIDTH]);
  assign w_pwm_raw  = $signed(PWMLimit[r_ch*WIDTH +: WIDTH]);
  assign w_ilim_raw = $signed(IntegralLimit[r_ch*WIDTH +: WIDTH]);
  assign w_db       = $signed(deadband[r_ch*WIDTH +: WIDTH]);
  assign w_integ    = r_integral[r_ch];

  // Negative limits collapse to zero, so the symmetric clamps below are safe
  assign w_pwm  = w_pwm_raw[WIDTH-1]  ? '0 : w_pwm_raw;
  assign w_ilim = w_ilim_raw[WIDTH-1] ? '0 : w_ilim_raw;

  // Deadband test one bit wider so |most-negative err| does not overflow
  logic signed [WIDTH:0] w_err_x, w_abs_err;
  logic                  w_in_db;
  assign w_err_x   = (WIDTH+1)'(r_err);
  assign w_abs_err = w_err_x[WIDTH] ? -w_err_x : w_err_x;
  assign w_in_db   = (w_abs_err <= (WIDTH+1)'(w_db));

  // Integral accumulate and clamp, also one bit wider
  logic signed [WIDTH:0]   w_int_sum, w_ilim_x;
  logic signed [WIDTH-1:0] w_int_next;
  assign w_int_sum = (WIDTH+1)'(w_integ) + (WIDTH+1)'(r_err);
  assign w_ilim_x  = (WIDTH+1)'(w_ilim);
  always_comb begin
    w_int_next = w_int_sum[WIDTH-1:0];
    if (w_int_sum > w_ilim_x)
      w_int_next = w_ilim;
    else if (w_int_sum < -w_ilim_x)
      w_int_next = -w_ilim;
  end

  // Output saturation against the full-width sum
  logic signed [SW-1:0]    w_pwm_s;
  logic signed [WIDTH-1:0] w_sat, w_duty_next;
  assign w_pwm_s = SW'(w_pwm);
  always_comb begin
    w_sat = r_sum[WIDTH-1:0];
    if (r_sum > w_pwm_s)
      w_sat = w_pwm;
    else if (r_sum < -w_pwm_s)
      w_sat = -w_pwm;
  end
  assign w_duty_next = w_in_db ? '0 : w_sat;

`ifdef PID_DERIVATIVE_EN
  localparam int KD_W = (KD_DIV > 1) ? $clog2(KD_DIV) : 1;
  localparam logic [KD_W-1:0] KD_LAST = KD_W'(KD_DIV - 1);

  logic signed [WIDTH-1:0] r_err_prev [CHANNELS];
  logic [KD_W-1:0]         r_sweep;
  logic signed [WIDTH-1:0] w_kd;
  logic signed [WIDTH:0]   w_ddiff;

  assign w_kd    = $signed(Kd[r_ch*WIDTH +: WIDTH]);
  assign w_ddiff = (WIDTH+1)'(r_err_prev[r_ch]) - (WIDTH+1)'(r_err);
`else
  logic w_unused_kd;
  assign w_unused_kd = ^Kd;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_fsm   <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ch    <= '0;
      r_err   <= '0;
      r_pterm <= '0;
      r_iterm <= '0;
      r_dterm <= '0;
      r_sum   <= '0;
      r_duty  <= '0;
      for (int i = 0; i < CHANNELS; i++) r_integral[i] <= '0;
`ifdef PID_DERIVATIVE_EN
      for (int i = 0; i < CHANNELS; i++) r_err_prev[i] <= '0;
      r_sweep <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (start) begin
            r_fsm  <= LOAD;
            r_busy <= 1'b1;
            r_ch   <= '0;
          end
        end
        LOAD: begin
          r_err <= w_st - w_sp;
          r_fsm <= MUL;
        end
        MUL: begin
          r_pterm <= PW'(w_kp) * PW'(r_err);
          r_iterm <= PW'(w_ki) * PW'(w_integ);
`ifdef PID_DERIVATIVE_EN
          r_dterm <= PW'(w_kd) * PW'(w_ddiff);
`else
          r_dterm <= '0;
`endif
          r_fsm <= SUM;
        end
        SUM: begin
          r_sum <= (SW'(r_pterm) + SW'(r_iterm) + SW'(r_dterm)) >>> FRAC_BITS;
          r_fsm <= STORE;
        end
        STORE: begin
          r_duty[r_ch*WIDTH +: WIDTH] <= w_duty_next;
          if (!w_in_db)
            r_integral[r_ch] <= w_int_next;
`ifdef PID_DERIVATIVE_EN
          if (r_sweep == '0)
            r_err_prev[r_ch] <= r_err;
`endif
          if (r_ch == LAST_CH) begin
            r_fsm  <= IDLE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
`ifdef PID_DERIVATIVE_EN
            r_sweep <= (r_sweep == KD_LAST) ? '0 : r_sweep + 1'b1;
`endif
          end else begin
            r_ch  <= r_ch + 1'b1;
            r_fsm <= LOAD;
          end
        end
        default: begin
          r_fsm  <= IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign duty = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_pid_controller_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pid_controller_mc
//  Description : Self-checking bench for pid_controller_mc. A vector table
//                drives single sweeps on channel 0; hand sequences cover
//                integral accumulation, deadband hold, mid-sweep reset,
//                start-while-busy and the derivative term. Expected results
//                are queued when a sweep is started and compared on done.
//                Channels 1..3 run a fixed Kp=1 load as an independence check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_controller_mc;

  localparam int W  = 24;
  localparam int CH = 4;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [CH*W-1:0] setpoint = '0, state = '0, Kp = '0, Ki = '0, Kd = '0;
  logic [CH*W-1:0] PWMLimit = '0, IntegralLimit = '0, deadband = '0;
  logic [CH*W-1:0] duty;

  pid_controller_mc #(
    .WIDTH(W), .CHANNELS(CH), .FRAC_BITS(0), .KD_DIV(1)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy), .done(done),
    .setpoint(setpoint), .state(state), .Kp(Kp), .Ki(Ki), .Kd(Kd),
    .PWMLimit(PWMLimit), .IntegralLimit(IntegralLimit),
    .deadband(deadband), .duty(duty)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int duty0;
    int lat;
  } sb_item_t;
  sb_item_t sb [$];

  typedef struct {
    string nm;
    int sp, st, kp, pwm, db, exp0;
  } vec_t;

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_ch0(input int sp, st, kp, ki, kd, pwm, ilim, db);
    setpoint[0 +: W]      = W'(sp);
    state[0 +: W]         = W'(st);
    Kp[0 +: W]            = W'(kp);
    Ki[0 +: W]            = W'(ki);
    Kd[0 +: W]            = W'(kd);
    PWMLimit[0 +: W]      = W'(pwm);
    IntegralLimit[0 +: W] = W'(ilim);
    deadband[0 +: W]      = W'(db);
  endtask

  task automatic apply_reset();
    @(negedge CLK); reset = 1'b1;
    @(negedge CLK); reset = 1'b0;
  endtask

  // One sweep; poke > 0 re-pulses start at that cycle to check it is ignored
  task automatic do_sweep(input string nm, input int exp0, input int poke);
    sb_item_t it;
    int cnt, ndone;
    bit seen;
    it.duty0 = exp0;
    it.lat   = 4*CH + 1;
    sb.push_back(it);
    @(negedge CLK); start = 1'b1;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge CLK); #1;
      cnt++;
      start = (poke > 0 && cnt == poke);
      if (cnt == 1) check({nm, "_busy"}, busy, 1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    it = sb.pop_front();
    if (!seen) begin
      check({nm, "_done_timeout"}, cnt, it.lat);
    end else begin
      check({nm, "_latency"}, cnt, it.lat);
      check({nm, "_duty0"}, $signed(duty[0 +: W]), it.duty0);
      check({nm, "_busy_end"}, busy, 0);
      for (int c = 1; c < CH; c++)
        check($sformatf("%s_duty%0d", nm, c), $signed(duty[c*W +: W]), c*7);
      if (poke > 0) begin
        ndone = 0;
        repeat (25) begin
          @(posedge CLK); #1;
          if (done) ndone++;
        end
        check({nm, "_extra_done"}, ndone, 0);
      end
    end
  endtask

  vec_t vt [8];
  int   ndone;
  int   exp_d;

  initial begin
    // ch0 table: sp, st, kp, pwm, deadband, expected duty0 (Ki = Kd = 0)
    vt[0] = '{"prop",      0,   100, 2, 1000, 0,   200};
    vt[1] = '{"sat_pos",   0,  1000, 2, 1000, 0,  1000};
    vt[2] = '{"sat_neg",   0, -1000, 2, 1000, 0, -1000};
    vt[3] = '{"neg_err",  50,    20, 3, 1000, 0,   -90};
    vt[4] = '{"db_edge",   0,     5, 3, 1000, 5,     0};
    vt[5] = '{"db_out",    0,     6, 3, 1000, 5,    18};
    vt[6] = '{"db_out_n",  0,    -6, 3, 1000, 5,   -18};
    vt[7] = '{"neg_pwm",   0,   100, 2,   -5, 0,     0};

    for (int c = 1; c < CH; c++) begin
      Kp[c*W +: W]       = W'(1);
      state[c*W +: W]    = W'(c*7);
      PWMLimit[c*W +: W] = W'(1000);
    end

    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_duty", duty, 0);
    @(negedge CLK); reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      set_ch0(vt[i].sp, vt[i].st, vt[i].kp, 0, 0, vt[i].pwm, 0, vt[i].db);
      do_sweep(vt[i].nm, vt[i].exp0, 0);
    end

    // Integral accumulation and clamp; second sweep also re-pulses start
    apply_reset();
    set_ch0(0, 10, 0, 1, 0, 1000, 25, 0);
    do_sweep("int1", 0, 0);
    do_sweep("int2", 10, 8);
    do_sweep("int3", 20, 0);
    do_sweep("int4", 25, 0);
    do_sweep("int5", 25, 0);

    // Deadband holds the integral: err=5 inside, then err=6 outside twice
    apply_reset();
    set_ch0(0, 5, 3, 1, 0, 1000, 100, 5);
    do_sweep("dbh1", 0, 0);
    set_ch0(0, 6, 3, 1, 0, 1000, 100, 5);
    do_sweep("dbh2", 18, 0);
    do_sweep("dbh3", 24, 0);

    // Reset 6 cycles into a sweep aborts it with no done pulse
    @(negedge CLK); start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    repeat (5) @(posedge CLK);
    #1; reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_duty", duty, 0);
    @(negedge CLK); reset = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(posedge CLK); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_duty_hold", duty, 0);
    set_ch0(0, 100, 2, 0, 0, 1000, 0, 0);
    do_sweep("after_abort", 200, 0);

    // Derivative term, KD_DIV=1 so err_prev is captured every sweep
    apply_reset();
    set_ch0(0, 0, 0, 0, 4, 1000, 0, 0);
    do_sweep("deriv0", 0, 0);
    set_ch0(0, 10, 0, 0, 4, 1000, 0, 0);
`ifdef PID_DERIVATIVE_EN
    exp_d = -40;
`else
    exp_d = 0;
`endif
    do_sweep("deriv1", exp_d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
